// File: rtl/sseg_pkg.sv
// Shared seven-segment encoding tables and anode codes, used by both the display
// driver and the receive-side decoder so the two can never disagree.
package sseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_D0   = 4'b1110;
    localparam logic [3:0] AN_D1   = 4'b1101;
    localparam logic [3:0] AN_D2   = 4'b1011;
    localparam logic [3:0] AN_D3   = 4'b0111;
    localparam logic [3:0] AN_NONE = 4'b1111;

    typedef enum logic [1:0] {
        AN_KIND_DIGIT,
        AN_KIND_BLANK,
        AN_KIND_ILLEGAL
    } anKind_t;

    typedef struct packed {
        anKind_t    kind;
        logic [1:0] idx;
    } anDecode_t;

    function automatic anDecode_t classifyAnode(input logic [3:0] an);
        anDecode_t res;
        res.kind = AN_KIND_DIGIT;
        res.idx  = 2'd0;
        case (an)
            AN_D0:   res.idx = 2'd0;
            AN_D1:   res.idx = 2'd1;
            AN_D2:   res.idx = 2'd2;
            AN_D3:   res.idx = 2'd3;
            AN_NONE: res.kind = AN_KIND_BLANK;
            default: res.kind = AN_KIND_ILLEGAL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// Inverse glyph lookup: active-low 7-segment pattern to hex value plus a hit flag
// that is low for any pattern that is not one of the sixteen hex glyphs.
module sseg_to_hex
    import sseg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic [3:0] value_o
);

    always_comb begin
        hit_o   = 1'b1;
        value_o = 4'h0;
        case (seg_i)
            SEG_0:   value_o = 4'h0;
            SEG_1:   value_o = 4'h1;
            SEG_2:   value_o = 4'h2;
            SEG_3:   value_o = 4'h3;
            SEG_4:   value_o = 4'h4;
            SEG_5:   value_o = 4'h5;
            SEG_6:   value_o = 4'h6;
            SEG_7:   value_o = 4'h7;
            SEG_8:   value_o = 4'h8;
            SEG_9:   value_o = 4'h9;
            SEG_A:   value_o = 4'hA;
            SEG_B:   value_o = 4'hB;
            SEG_C:   value_o = 4'hC;
            SEG_D:   value_o = 4'hD;
            SEG_E:   value_o = 4'hE;
            SEG_F:   value_o = 4'hF;
            default: hit_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/sseg_display_decoder.sv
// Captures a multiplexed seven-segment display: synchronizes the anode/cathode lines,
// waits for each pattern to be stable, then decodes it back into four hex digit registers.
module sseg_display_decoder
    import sseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] an_i,
    input  logic [7:0] sseg_i,
    output logic [3:0] d0_o,
    output logic [3:0] d1_o,
    output logic [3:0] d2_o,
    output logic [3:0] d3_o,
    output logic [3:0] dp_o,
    output logic [3:0] dig_valid_o,
    output logic       frame_done_o,
    output logic       err_o
);

    localparam int RUN_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][11:0] sync_q;
    logic [11:0]                  prev_q;
    logic [RUN_W-1:0]             runCnt_q, runCnt_d;
    logic                         armed_q, armed_d;
    logic [3:0][3:0]              digit_q, digit_d;
    logic [3:0]                   dp_q, dp_d;
    logic [3:0]                   digValid_q, digValid_d;
    logic [3:0]                   seen_q, seen_d;
    logic                         frameDone_q, frameDone_d;
    logic                         err_q, err_d;

    logic [11:0] sample;
    logic        change;
    logic        armedNow;
    logic        accept;
    logic        hexHit;
    logic [3:0]  hexValue;
    anDecode_t   anDec;
    logic [3:0]  newSeen;

    assign sample = sync_q[SYNC_STAGES-1];

    sseg_to_hex u_sseg_to_hex (
        .seg_i   (sample[6:0]),
        .hit_o   (hexHit),
        .value_o (hexValue)
    );

    // Lines idle high, so the synchronizer and compare register reset to all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '1;
            prev_q   <= '1;
            runCnt_q <= '0;
            armed_q  <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], {an_i, sseg_i}};
            prev_q   <= sample;
            runCnt_q <= runCnt_d;
            armed_q  <= armed_d;
        end
    end

    // The run value seen this cycle is 0 on a change, so STABLE_CYCLES=1 accepts immediately.
    always_comb begin
        change = (sample != prev_q);
        if (change) begin
            runCnt_d = '0;
        end else if (runCnt_q == RUN_MAX) begin
            runCnt_d = runCnt_q;
        end else begin
            runCnt_d = runCnt_q + RUN_W'(1);
        end
        armedNow = armed_q | change;
        accept   = armedNow & (runCnt_d == RUN_MAX);
        armed_d  = armedNow & ~accept;
    end

    always_comb begin
        digit_d     = digit_q;
        dp_d        = dp_q;
        digValid_d  = digValid_q;
        seen_d      = seen_q;
        frameDone_d = 1'b0;
        err_d       = 1'b0;
        newSeen     = seen_q;
        anDec       = classifyAnode(sample[11:8]);
        if (accept) begin
            case (anDec.kind)
                AN_KIND_DIGIT: begin
                    if (hexHit) begin
                        digit_d[anDec.idx]    = hexValue;
                        digValid_d[anDec.idx] = 1'b1;
                        dp_d[anDec.idx]       = ~sample[7];
                        newSeen               = seen_q | (4'b0001 << anDec.idx);
                        if (newSeen == 4'b1111) begin
                            frameDone_d = 1'b1;
                            seen_d      = 4'b0000;
                        end else begin
                            seen_d = newSeen;
                        end
                    end else begin
                        err_d                 = 1'b1;
                        digValid_d[anDec.idx] = 1'b0;
                    end
                end
                AN_KIND_ILLEGAL: err_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q     <= '0;
            dp_q        <= '0;
            digValid_q  <= '0;
            seen_q      <= '0;
            frameDone_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            digit_q     <= digit_d;
            dp_q        <= dp_d;
            digValid_q  <= digValid_d;
            seen_q      <= seen_d;
            frameDone_q <= frameDone_d;
            err_q       <= err_d;
        end
    end

    assign d0_o         = digit_q[0];
    assign d1_o         = digit_q[1];
    assign d2_o         = digit_q[2];
    assign d3_o         = digit_q[3];
    assign dp_o         = dp_q;
    assign dig_valid_o  = digValid_q;
    assign frame_done_o = frameDone_q;
    assign err_o        = err_q;

endmodule
